board_init: RTL and testbench
=============================

BOARD_INIT -- requirements
Module: board_init

Interface
REQ-001 SHALL provide parameter N, default 4, meaning board side length; N*N SHALL be a power of two (2x2, 4x4, 8x8 legal).
REQ-002 SHALL provide parameter CELL_W, default 4, meaning bits per cell (log2 tile exponent, 0 = empty).
REQ-003 SHALL provide parameter INIT_TILES, default 2, meaning tiles placed per init; legal range 1..N*N.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_input  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  request board initialisation; sampled in IDLE only.
REQ-007 seed_load  input  1  load seed into LFSR; honoured in IDLE only.
REQ-008 seed  input  16  LFSR seed value.
REQ-009 busy  output  1  high in CLEAR and PICK.
REQ-010 done  output  1  one-cycle pulse when init completes.
REQ-011 board_out  output  N*N*CELL_W  registered board, cell i at bits [i*CELL_W +: CELL_W], cell 0 = top-left, row-major.
REQ-012 tiles_placed  output  clog2(N*N+1)  count of tiles placed in current/last init.

Function
REQ-013 FSM states SHALL be IDLE, CLEAR, PICK, DONE.
REQ-014 IDLE: start=1 -> CLEAR next cycle; seed_load=1 and start=1 same cycle -> seed loaded and CLEAR entered.
REQ-015 CLEAR SHALL last exactly 1 cycle: all cells <= 0, tiles_placed <= 0, then PICK.
REQ-016 LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifts every cycle in every state (free-running).
REQ-017 Seed 16'h0000 SHALL be replaced by 16'hACE1 on load (LFSR never all-zero).
REQ-018 PICK: candidate index = LFSR[clog2(N*N)-1:0] of current cycle; if candidate cell == 0, cell <= tile value and tiles_placed increments same edge; otherwise no write, retry next cycle.
REQ-019 PICK -> DONE on the edge where tiles_placed reaches INIT_TILES; no cell SHALL be written twice within one init.
REQ-020 DONE: done=1 for exactly one cycle, busy=0, then IDLE.
REQ-021 start, seed_load while busy or in DONE SHALL be ignored (no restart, no seed change).
REQ-022 board_out SHALL hold its value in IDLE until next CLEAR; partial board visible during PICK.
REQ-023 Minimum latency start-sample to done = INIT_TILES+2 cycles (CLEAR 1, PICK >= INIT_TILES, DONE asserted in following cycle).
REQ-024 INIT_TILES == N*N SHALL terminate (LFSR period 65535 covers every index).

Reset
REQ-025 reset_input=1 SHALL immediately force: state IDLE, board_out all 0, busy 0, done 0, tiles_placed 0, LFSR 16'hACE1.
REQ-026 Reset mid-CLEAR/PICK/DONE SHALL abort init; no done pulse issued.
REQ-027 After release, first start SHALL produce a full init sequence from IDLE.

Configuration
REQ-028 Macro BOARD_INIT_FOUR_TILE_EN SHALL control placed tile value.
REQ-029 Defined: tile value = 2 (tile "4") when LFSR[15:12]==4'h0 at placement cycle, else 1 (tile "2").
REQ-030 Undefined: tile value always 1; LFSR[15:12] unused.

Verification
REQ-031 Assert reset_input mid-sim -> board_out=0, busy=0, done=0, tiles_placed=0 same cycle, no clock needed.
REQ-032 N=4, INIT_TILES=2, seed_load with seed=16'h0001 then start -> exactly 2 nonzero cells at done, tiles_placed=2, done high 1 cycle, macro undefined: both cells =1; rerun with same seed gives identical board.
REQ-033 N=2, INIT_TILES=4, seed=16'h0000 -> behaves as seed 16'hACE1, all 4 cells nonzero at done, no cell rewritten.
REQ-034 start pulsed every cycle while busy -> single init, single done pulse; seed_load during PICK -> LFSR sequence unchanged vs reference run.
REQ-035 reset_input asserted 1 cycle into PICK -> board 0, IDLE, no done; next start completes normally with 2 tiles.
REQ-036 BOARD_INIT_FOUR_TILE_EN defined, 1000 inits from fixed seed -> value-2 tiles appear, occurring only when LFSR[15:12]==0 at placement (checked by model).

Source files
------------

// File: rtl/board_init.sv
// Board initialiser: clears an N x N board, then drops INIT_TILES tiles on empty cells chosen by a free-running LFSR.
// Optional BOARD_INIT_FOUR_TILE_EN: a placed tile becomes value 2 when LFSR[15:12]==0, otherwise it is value 1.
module board_init #(
    parameter int N          = 4,
    parameter int CELL_W     = 4,
    parameter int INIT_TILES = 2
) (
    input  logic                              clk,
    input  logic                              reset_input,
    input  logic                              start,
    input  logic                              seed_load,
    input  logic [15:0]                       seed,
    output logic                              busy,
    output logic                              done,
    output logic [N*N*CELL_W-1:0]             board_out,
    output logic [$clog2(N*N+1)-1:0]          tiles_placed
);

    localparam int CELLS = N * N;
    localparam int IDXW  = $clog2(CELLS);
    localparam int TPW   = $clog2(CELLS + 1);
    localparam logic [TPW-1:0]  TILES_TGT = TPW'(INIT_TILES);
    localparam logic [15:0]     LFSR_INIT = 16'hACE1;

    typedef enum logic [1:0] {IDLE, CLEAR, PICK, DONE} state_t;

    state_t             state;
    logic [15:0]        lfsr;
    logic [15:0]        lfsr_next;
    logic [IDXW-1:0]    idx;
    logic [CELL_W-1:0]  cand;
    logic [CELL_W-1:0]  tile_val;
    logic [TPW-1:0]     tiles_inc;

    // Taps for x^16+x^14+x^13+x^11+1
    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign idx       = lfsr[IDXW-1:0];
    assign cand      = board_out[int'(idx)*CELL_W +: CELL_W];
    assign tiles_inc = tiles_placed + TPW'(1);

    always_comb begin
        tile_val = CELL_W'(1);
`ifdef BOARD_INIT_FOUR_TILE_EN
        if (lfsr[15:12] == 4'h0)
            tile_val = CELL_W'(2);
`endif
    end

    always_ff @(posedge clk or posedge reset_input) begin
        if (reset_input) begin
            state        <= IDLE;
            lfsr         <= LFSR_INIT;
            board_out    <= '0;
            tiles_placed <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            lfsr <= lfsr_next;
            case (state)
                IDLE: begin
                    if (seed_load)
                        lfsr <= (seed == 16'h0000) ? LFSR_INIT : seed;
                    if (start) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    board_out    <= '0;
                    tiles_placed <= '0;
                    state        <= PICK;
                end
                PICK: begin
                    // Occupied candidate: no write, the next LFSR value is tried next cycle
                    if (cand == '0) begin
                        board_out[int'(idx)*CELL_W +: CELL_W] <= tile_val;
                        tiles_placed <= tiles_inc;
                        if (tiles_inc == TILES_TGT) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_init.sv
// Scoreboard bench for board_init: a 4x4/2-tile instance and a 2x2/4-tile instance checked against an LFSR model.
module tb_board_init;

    typedef struct {
        logic [63:0] board;
        int          tiles;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_input;
    logic        st [2];
    logic        sl [2];
    logic [15:0] sd [2];
    logic        busy4, done4, busy2, done2;
    logic [63:0] board4;
    logic [15:0] board2;
    logic [4:0]  tp4;
    logic [2:0]  tp2;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   twos_seen = 0;

    always #5 clk = ~clk;

    board_init #(.N(4), .CELL_W(4), .INIT_TILES(2)) dut4 (
        .clk(clk), .reset_input(reset_input), .start(st[0]), .seed_load(sl[0]), .seed(sd[0]),
        .busy(busy4), .done(done4), .board_out(board4), .tiles_placed(tp4)
    );

    board_init #(.N(2), .CELL_W(4), .INIT_TILES(4)) dut2 (
        .clk(clk), .reset_input(reset_input), .start(st[1]), .seed_load(sl[1]), .seed(sd[1]),
        .busy(busy2), .done(done2), .board_out(board2), .tiles_placed(tp2)
    );

    function automatic logic [15:0] lstep(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Reference: first PICK cycle sees the loaded seed advanced once (the CLEAR cycle shifts it)
    function automatic exp_t predict(input int cells, input int tiles, input logic [15:0] sv);
        exp_t        e;
        logic [15:0] l;
        logic [3:0]  v;
        int          placed, picks, idx;
        l = (sv == 16'h0000) ? 16'hACE1 : sv;
        l = lstep(l);
        e.board = '0;
        placed = 0;
        picks  = 0;
        while (placed < tiles && picks < 100000) begin
            idx = int'(l) % cells;
            if (e.board[idx*4 +: 4] == 4'h0) begin
                v = 4'h1;
`ifdef BOARD_INIT_FOUR_TILE_EN
                if (l[15:12] == 4'h0) v = 4'h2;
`endif
                e.board[idx*4 +: 4] = v;
                placed++;
            end
            picks++;
            l = lstep(l);
        end
        e.tiles = placed;
        e.lat   = picks + 2;
        return e;
    endfunction

    function automatic logic dn(input int w);
        return (w == 0) ? done4 : done2;
    endfunction
    function automatic logic bz(input int w);
        return (w == 0) ? busy4 : busy2;
    endfunction
    function automatic logic [63:0] bd(input int w);
        return (w == 0) ? board4 : {48'h0, board2};
    endfunction
    function automatic int tp(input int w);
        return (w == 0) ? int'(tp4) : int'(tp2);
    endfunction

    // One init with seed load; spam keeps hammering start/seed_load (random seeds) while the DUT is busy
    task automatic run_init(input int w, input logic [15:0] sv, input bit spam);
        exp_t e;
        int   cyc, busy_bad, extra_done, nz;
        logic [63:0] b;
        @(negedge clk);
        st[w] = 1'b1; sl[w] = 1'b1; sd[w] = sv;
        sb.push_back(predict((w == 0) ? 16 : 4, (w == 0) ? 2 : 4, sv));
        cyc = 0; busy_bad = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (dn(w) || cyc > 3000) break;
            if (!bz(w)) busy_bad++;
            if (spam) begin
                st[w] = 1'b1; sl[w] = 1'b1; sd[w] = 16'($urandom);
            end else begin
                st[w] = 1'b0; sl[w] = 1'b0;
            end
        end
        st[w] = 1'b0; sl[w] = 1'b0;
        e = sb.pop_front();
        b = bd(w);
        n_checks++;
        if (cyc !== e.lat) begin n_fail++; $display("FAIL latency: got %0d expected %0d", cyc, e.lat); end
        n_checks++;
        if (b !== e.board) begin n_fail++; $display("FAIL board: got %h expected %h", b, e.board); end
        n_checks++;
        if (tp(w) !== e.tiles) begin n_fail++; $display("FAIL tiles_placed: got %0d expected %0d", tp(w), e.tiles); end
        n_checks++;
        if (busy_bad !== 0) begin n_fail++; $display("FAIL busy_while_running: got %0d low cycles expected 0", busy_bad); end
        n_checks++;
        if (bz(w) !== 1'b0) begin n_fail++; $display("FAIL busy_in_done: got %b expected 0", bz(w)); end
        nz = 0;
        for (int i = 0; i < 16; i++) begin
            if (b[i*4 +: 4] != 4'h0) nz++;
            if (b[i*4 +: 4] == 4'h2) twos_seen++;
        end
        n_checks++;
        if (nz !== e.tiles) begin n_fail++; $display("FAIL nonzero_cells: got %0d expected %0d", nz, e.tiles); end
        @(negedge clk);
        n_checks++;
        if (dn(w) !== 1'b0) begin n_fail++; $display("FAIL done_width: got %b expected 0", dn(w)); end
        if (spam) begin
            extra_done = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (dn(w) || bz(w)) extra_done++;
            end
            n_checks++;
            if (extra_done !== 0) begin n_fail++; $display("FAIL single_init: got %0d extra busy/done cycles expected 0", extra_done); end
        end
    endtask

    task automatic check_zero(input int w, input string tag);
        n_checks++;
        if (bd(w) !== 64'h0) begin n_fail++; $display("FAIL %s board: got %h expected 0", tag, bd(w)); end
        n_checks++;
        if (bz(w) !== 1'b0) begin n_fail++; $display("FAIL %s busy: got %b expected 0", tag, bz(w)); end
        n_checks++;
        if (dn(w) !== 1'b0) begin n_fail++; $display("FAIL %s done: got %b expected 0", tag, dn(w)); end
        n_checks++;
        if (tp(w) !== 0) begin n_fail++; $display("FAIL %s tiles_placed: got %0d expected 0", tag, tp(w)); end
    endtask

    task automatic test_reset;
        reset_input = 1'b1;
        st = '{1'b0, 1'b0}; sl = '{1'b0, 1'b0}; sd = '{16'h0, 16'h0};
        #12;
        check_zero(0, "reset_n4");
        check_zero(1, "reset_n2");
        @(negedge clk);
        reset_input = 1'b0;
    endtask

    task automatic test_seed_one;
        logic [63:0] b;
        int ones;
        run_init(0, 16'h0001, 1'b0);
        b = bd(0);
        ones = 0;
        for (int i = 0; i < 16; i++) if (b[i*4 +: 4] == 4'h1) ones++;
`ifndef BOARD_INIT_FOUR_TILE_EN
        n_checks++;
        if (ones !== 2) begin n_fail++; $display("FAIL seed1_cells_one: got %0d expected 2", ones); end
`endif
        run_init(0, 16'h0001, 1'b0);
    endtask

    task automatic test_zero_seed;
        run_init(1, 16'h0000, 1'b0);
        run_init(1, 16'hACE1, 1'b0);
        run_init(1, 16'h5A5A, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_init(0, 16'hBEEF, 1'b1);
        run_init(1, 16'h1357, 1'b1);
    endtask

    task automatic test_reset_mid;
        int seen;
        @(negedge clk);
        st[0] = 1'b1; sl[0] = 1'b1; sd[0] = 16'h1234;
        @(negedge clk);
        st[0] = 1'b0; sl[0] = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 reset_input = 1'b1;
        #1 check_zero(0, "reset_mid");
        @(negedge clk);
        reset_input = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done4 || busy4) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL reset_abort: got %0d busy/done cycles expected 0", seen); end
        run_init(0, 16'h0001, 1'b0);
    endtask

    task automatic test_many_inits;
        for (int i = 0; i < 1000; i++)
            run_init(0, 16'hC0DE ^ 16'(i * 16'h9E37), 1'b0);
        n_checks++;
`ifdef BOARD_INIT_FOUR_TILE_EN
        if (twos_seen == 0) begin n_fail++; $display("FAIL four_tiles: got %0d expected >0", twos_seen); end
`else
        if (twos_seen !== 0) begin n_fail++; $display("FAIL four_tiles: got %0d expected 0", twos_seen); end
`endif
    endtask

    initial begin
        test_reset;
        test_seed_one;
        test_zero_seed;
        test_back_to_back;
        test_reset_mid;
        test_many_inits;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
